// File: rtl/wts_tone_pkg.sv
// wts_tone_pkg: shared types and wave-length helper for the wave-table tone generator.
package wts_tone_pkg;
  typedef logic [1:0] wts_len_code_t;
  localparam int unsigned WTS_BASE_LEN = 32;
  function automatic int unsigned wts_last_addr(wts_len_code_t code, int unsigned addr_w);
    int unsigned len;
    int unsigned cap;
    len = WTS_BASE_LEN << code;
    cap = 32'd1 << addr_w;
    return (len < cap ? len : cap) - 1;
  endfunction
endpackage

// File: rtl/wts_tone_channel.sv
// wts_tone_channel: one tone channel with divider, wave address, one-shot halt and wrap pulse.
module wts_tone_channel
  import wts_tone_pkg::*;
#(
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              active,
  input  logic              address_reset,
  input  logic [FREQ_W-1:0] frequency_count,
  input  wts_len_code_t     wave_length,
  input  logic              one_shot,
  output logic [ADDR_W-1:0] wave_address,
  output logic              wrap_pulse,
  output logic              done
);
  logic [FREQ_W-1:0] count;
  logic [ADDR_W-1:0] last;
  assign last = ADDR_W'(wts_last_addr(wave_length, ADDR_W));
  // an address beyond a shrunk length is treated as the last sample
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      count <= '0;
      wave_address <= '0;
      wrap_pulse <= 1'b0;
      done <= 1'b0;
    end else begin
      wrap_pulse <= 1'b0;
      if (active) begin
        if (address_reset) begin
          count <= frequency_count;
          wave_address <= '0;
          done <= 1'b0;
        end else if (!done) begin
          if (count != '0) count <= count - 1'b1;
          else begin
            count <= frequency_count;
            if (wave_address < last) wave_address <= wave_address + 1'b1;
            else begin
              wrap_pulse <= 1'b1;
              if (one_shot) done <= 1'b1;
              else wave_address <= '0;
            end
          end
        end
      end
    end
  end
endmodule

// File: rtl/wts_multi_tone_generator.sv
// wts_multi_tone_generator: CH_NUM independent wave-table tone channels on flattened register buses.
module wts_multi_tone_generator
  import wts_tone_pkg::*;
#(
  parameter int CH_NUM = 5,
  parameter int FREQ_W = 12,
  parameter int ADDR_W = 7
) (
  input  logic                     nreset,
  input  logic                     clk,
  input  logic                     active,
  input  logic [CH_NUM-1:0]        address_reset,
  input  logic [CH_NUM*FREQ_W-1:0] reg_frequency_count,
  input  logic [CH_NUM*2-1:0]      reg_wave_length,
  input  logic [CH_NUM-1:0]        reg_one_shot,
  output logic [CH_NUM*ADDR_W-1:0] wave_address,
  output logic [CH_NUM-1:0]        wrap_pulse,
  output logic [CH_NUM-1:0]        done
);
  genvar i;
  for (i = 0; i < CH_NUM; i++) begin : g_ch
    wts_tone_channel #(.FREQ_W(FREQ_W), .ADDR_W(ADDR_W)) u_ch (
      .clk            (clk),
      .nreset         (nreset),
      .active         (active),
      .address_reset  (address_reset[i]),
      .frequency_count(reg_frequency_count[i*FREQ_W +: FREQ_W]),
      .wave_length    (wts_len_code_t'(reg_wave_length[i*2 +: 2])),
      .one_shot       (reg_one_shot[i]),
      .wave_address   (wave_address[i*ADDR_W +: ADDR_W]),
      .wrap_pulse     (wrap_pulse[i]),
      .done           (done[i])
    );
  end
endmodule

// File: tb/tb_wts_multi_tone_generator.sv
// tb_wts_multi_tone_generator: directed and random stimulus against a per-channel behavioural model.
module tb_wts_multi_tone_generator;
  localparam int CH = 2, FW = 12, AW = 7;
  logic nreset, clk, active;
  logic [CH-1:0] address_reset, reg_one_shot, wrap_pulse, done;
  logic [CH*FW-1:0] reg_frequency_count;
  logic [CH*2-1:0] reg_wave_length;
  logic [CH*AW-1:0] wave_address;
  int n_assert = 0, n_fail = 0;
  int m_cnt[CH], m_addr[CH], wraps[CH];
  bit m_done[CH], m_wrap[CH];

  wts_multi_tone_generator #(.CH_NUM(CH), .FREQ_W(FW), .ADDR_W(AW)) dut (
    .nreset(nreset), .clk(clk), .active(active), .address_reset(address_reset),
    .reg_frequency_count(reg_frequency_count), .reg_wave_length(reg_wave_length),
    .reg_one_shot(reg_one_shot), .wave_address(wave_address), .wrap_pulse(wrap_pulse), .done(done)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cnt[c] = 0; m_addr[c] = 0; m_done[c] = 0; m_wrap[c] = 0;
    end
  endtask

  task automatic check_all();
    logic [CH*AW-1:0] ea;
    logic [CH-1:0] ew, ed;
    for (int c = 0; c < CH; c++) begin
      ea[c*AW +: AW] = AW'(m_addr[c]);
      ew[c] = m_wrap[c];
      ed[c] = m_done[c];
    end
    chk("wave_address", 32'(wave_address), 32'(ea));
    chk("wrap_pulse", 32'(wrap_pulse), 32'(ew));
    chk("done", 32'(done), 32'(ed));
  endtask

  // Wave length is min(32<<L, 128); a channel steps once every N+1 active pulses.
  task automatic model_clk();
    int n, len;
    for (int c = 0; c < CH; c++) begin
      m_wrap[c] = 0;
      if (!nreset) begin
        m_cnt[c] = 0; m_addr[c] = 0; m_done[c] = 0;
      end else if (active) begin
        n = int'(reg_frequency_count[c*FW +: FW]);
        len = 32 << reg_wave_length[c*2 +: 2];
        if (len > 128) len = 128;
        if (address_reset[c]) begin
          m_cnt[c] = n; m_addr[c] = 0; m_done[c] = 0;
        end else if (!m_done[c]) begin
          if (m_cnt[c] > 0) m_cnt[c]--;
          else begin
            m_cnt[c] = n;
            if (m_addr[c] < len - 1) m_addr[c]++;
            else begin
              m_wrap[c] = 1;
              if (reg_one_shot[c]) m_done[c] = 1;
              else m_addr[c] = 0;
            end
          end
        end
      end
    end
  endtask

  task automatic tick(input bit act, input logic [CH-1:0] rr);
    @(negedge clk);
    active = act;
    address_reset = rr;
    @(posedge clk);
    model_clk();
    #1;
    check_all();
    for (int c = 0; c < CH; c++) if (wrap_pulse[c]) wraps[c]++;
  endtask

  task automatic pulse(input logic [CH-1:0] rr);
    tick(1'b1, rr);
    for (int k = 0; k < 5; k++) tick(1'b0, '0);
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) pulse('0);
  endtask

  task automatic set_ch(input int c, input int n, input int l, input bit os);
    reg_frequency_count[c*FW +: FW] = FW'(n);
    reg_wave_length[c*2 +: 2] = 2'(l);
    reg_one_shot[c] = os;
  endtask

  initial begin
    nreset = 0; active = 0; address_reset = '0;
    reg_frequency_count = '0; reg_wave_length = '0; reg_one_shot = '0;
    model_reset();
    #12;
    check_all();
    @(negedge clk) nreset = 1;

    // ch0 N=0 L=0 loop alongside ch1 N=2 L=1 loop
    set_ch(0, 0, 0, 0);
    set_ch(1, 2, 1, 0);
    pulse(2'b11);
    wraps[0] = 0; wraps[1] = 0;
    run(192);
    chk("ch0_wrap_count", 32'(wraps[0]), 32'd6);
    chk("ch1_wrap_count", 32'(wraps[1]), 32'd1);

    // one-shot ch0 N=1 L=0
    set_ch(0, 1, 0, 1);
    pulse(2'b01);
    wraps[0] = 0;
    run(64);
    chk("oneshot_addr", 32'(wave_address[AW-1:0]), 32'd31);
    chk("oneshot_done", 32'(done[0]), 32'd1);
    chk("oneshot_wraps", 32'(wraps[0]), 32'd1);
    run(5);
    chk("oneshot_hold", 32'(wave_address[AW-1:0]), 32'd31);
    reg_one_shot[0] = 0;
    run(3);
    tick(1'b1, 2'b01);
    chk("restart_addr", 32'(wave_address[AW-1:0]), 32'd0);
    chk("restart_done", 32'(done[0]), 32'd0);
    for (int k = 0; k < 5; k++) tick(1'b0, '0);

    // ch1 L=3 capped at 128 samples
    set_ch(1, 0, 3, 0);
    pulse(2'b10);
    run(127);
    chk("cap_last", 32'(wave_address[AW +: AW]), 32'd127);
    tick(1'b1, '0);
    chk("cap_wrap_addr", 32'(wave_address[AW +: AW]), 32'd0);
    chk("cap_wrap_pulse", 32'(wrap_pulse[1]), 32'd1);
    tick(1'b0, '0);
    chk("cap_wrap_clear", 32'(wrap_pulse[1]), 32'd0);
    for (int k = 0; k < 4; k++) tick(1'b0, '0);

    // restart coincident with a wrap step
    set_ch(0, 0, 0, 0);
    pulse(2'b01);
    run(31);
    tick(1'b1, 2'b01);
    chk("rst_vs_wrap_addr", 32'(wave_address[AW-1:0]), 32'd0);
    chk("rst_vs_wrap_pulse", 32'(wrap_pulse[0]), 32'd0);
    for (int k = 0; k < 5; k++) tick(1'b0, '0);

    // N 5 -> 0 mid-count
    set_ch(0, 5, 0, 0);
    pulse(2'b01);
    run(2);
    reg_frequency_count[FW-1:0] = '0;
    run(3);
    chk("n_change_pending", 32'(wave_address[AW-1:0]), 32'd0);
    run(1);
    chk("n_change_step", 32'(wave_address[AW-1:0]), 32'd1);
    run(1);
    chk("n_change_fast", 32'(wave_address[AW-1:0]), 32'd2);

    // L 1 -> 0 while address is 40
    set_ch(0, 0, 1, 0);
    pulse(2'b01);
    run(40);
    chk("shrink_pre", 32'(wave_address[AW-1:0]), 32'd40);
    reg_wave_length[1:0] = 2'd0;
    run(1);
    chk("shrink_wrap", 32'(wave_address[AW-1:0]), 32'd0);

    // random register traffic
    for (int it = 0; it < 60; it++) begin
      for (int c = 0; c < CH; c++)
        set_ch(c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      pulse(($urandom_range(0, 3) == 0) ? CH'($urandom) : '0);
      run(int'($urandom_range(1, 40)));
    end

    // asynchronous reset mid-wave with active running
    set_ch(0, 0, 2, 0);
    set_ch(1, 1, 1, 0);
    pulse(2'b11);
    run(20);
    @(negedge clk);
    active = 1;
    #2 nreset = 0;
    model_reset();
    #1;
    check_all();
    tick(1'b1, '0);
    tick(1'b0, '0);
    @(negedge clk) nreset = 1;
    for (int k = 0; k < 5; k++) tick(1'b0, '0);
    chk("post_reset_hold", 32'(wave_address), 32'd0);
    run(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
